mem_seq_ctrl: RTL and testbench

Sequencing controller for the vector processor's MEM stage. Decodes a memory-op request from the EX/MEM register and drives the MEM-stage controls: `sum_mem`, `sel_mem`, `sel_data`, `final_mem`. It also drives the RAM write enable, stalls the upstream pipeline for the duration of a vector burst, and tags returning load data for MEM/WB writeback. One scalar access or one N-element vector burst is handled at a time.

---
 rtl/mem_seq_ctrl_if.sv | 35 +++
 rtl/mem_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_ctrl_if.sv
// MEM-stage request/control bundle between the EX/MEM side and the sequencing
// controller; clk/rst are kept outside the interface.
interface mem_seq_ctrl_if;
    logic        op_valid;
    logic        op_mem;
    logic        op_store;
    logic        op_vector;
    logic        op_src_alu;
    logic [31:0] vec_len;

    logic        sum_mem;
    logic        sel_mem;
    logic        sel_data;
    logic [31:0] final_mem;
    logic        wren;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_idx;
    logic        busy;
    logic        done;

    // Pipeline / requester side
    modport master (
        output op_valid, op_mem, op_store, op_vector, op_src_alu, vec_len,
        input  sum_mem, sel_mem, sel_data, final_mem, wren, stall,
               wb_valid, wb_idx, busy, done
    );

    // Sequencing controller side
    modport slave (
        input  op_valid, op_mem, op_store, op_vector, op_src_alu, vec_len,
        output sum_mem, sel_mem, sel_data, final_mem, wren, stall,
               wb_valid, wb_idx, busy, done
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// MEM-stage sequencing controller: runs one scalar access or one N-element
// vector burst at a time, stalls upstream and tags returning load data.
module mem_seq_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

    state_e      state_q;
    logic [31:0] k_q;
    logic [31:0] final_mem_q;
    logic [2:0]  drain_cnt_q;
    logic        store_q;
    logic        src_alu_q;
    logic        sum_mem_q;
    logic        sel_mem_q;
    logic        wren_q;
    logic        busy_q;
    logic        done_q;

    logic [RD_LAT-1:0] ret_vld_q;
    logic [31:0]       ret_idx_q [RD_LAT];

    logic        accept;
    logic        issue_load;
    logic        last_elem;
    logic [31:0] issue_idx;

    assign accept     = (state_q == S_IDLE) && bus.op_valid && bus.op_mem;
    assign issue_load = ((state_q == S_SCALAR) || (state_q == S_STREAM)) && !store_q;
    assign issue_idx  = (state_q == S_STREAM) ? k_q : 32'd0;
    // final_mem_q holds N-1 for the whole burst, so it doubles as the last index.
    assign last_elem  = (k_q == final_mem_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            final_mem_q <= '0;
            drain_cnt_q <= '0;
            store_q     <= 1'b0;
            src_alu_q   <= 1'b0;
            sum_mem_q   <= 1'b0;
            sel_mem_q   <= 1'b0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ret_vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                ret_idx_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // Load-return pipe mirrors the RAM read latency.
            ret_vld_q[0] <= issue_load;
            ret_idx_q[0] <= issue_load ? issue_idx : 32'd0;
            for (int i = 1; i < RD_LAT; i++) begin
                ret_vld_q[i] <= ret_vld_q[i-1];
                ret_idx_q[i] <= ret_idx_q[i-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        store_q   <= bus.op_store;
                        src_alu_q <= bus.op_src_alu;
                        busy_q    <= 1'b1;
                        k_q       <= '0;
                        if (!bus.op_vector) begin
                            state_q     <= S_SCALAR;
                            sel_mem_q   <= 1'b1;
                            sum_mem_q   <= 1'b0;
                            wren_q      <= bus.op_store;
                            final_mem_q <= '0;
                        end else if (bus.vec_len != 32'd0) begin
                            state_q     <= S_STREAM;
                            sel_mem_q   <= 1'b0;
                            sum_mem_q   <= 1'b1;
                            wren_q      <= bus.op_store;
                            final_mem_q <= bus.vec_len - 32'd1;
                        end else begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            final_mem_q <= bus.vec_len - 32'd1;
                        end
                    end
                end

                S_SCALAR: begin
                    sel_mem_q <= 1'b0;
                    wren_q    <= 1'b0;
                    if (store_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= '0;
                    end
                end

                S_STREAM: begin
                    if (last_elem) begin
                        sum_mem_q <= 1'b0;
                        wren_q    <= 1'b0;
                        k_q       <= '0;
                        if (store_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end else begin
                        k_q <= k_q + 32'd1;
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end

                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    final_mem_q <= '0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum_mem   = sum_mem_q;
    assign bus.sel_mem   = sel_mem_q;
    assign bus.wren      = wren_q;
    assign bus.final_mem = final_mem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wb_valid  = ret_vld_q[RD_LAT-1];
    assign bus.wb_idx    = ret_idx_q[RD_LAT-1];
    // DONE drops stall so the held instruction retires on the DONE edge.
    assign bus.stall     = accept || (state_q == S_SCALAR) || (state_q == S_STREAM)
                           || (state_q == S_DRAIN);
    assign bus.sel_data  = busy_q ? src_alu_q : bus.op_src_alu;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl (RD_LAT=2) with a small PCMEM model of the MEM stage.
module tb_mem_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_seq_ctrl_if bus ();

    mem_seq_ctrl #(.RD_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // PCMEM counter as the MEM stage implements it.
    logic [31:0] pcmem;
    always_ff @(posedge clk) begin
        if (rst)               pcmem <= 32'd0;
        else if (bus.sum_mem)  pcmem <= (pcmem == bus.final_mem) ? 32'd0 : pcmem + 32'd1;
    end

    // {wren, sum_mem, sel_mem, stall, busy, done, wb_valid}
    wire [6:0] ctl = {bus.wren, bus.sum_mem, bus.sel_mem, bus.stall,
                      bus.busy, bus.done, bus.wb_valid};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic valid, input logic mem, input logic store,
                            input logic vector, input logic src, input logic [31:0] n);
        bus.op_valid   = valid;
        bus.op_mem     = mem;
        bus.op_store   = store;
        bus.op_vector  = vector;
        bus.op_src_alu = src;
        bus.vec_len    = n;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_op(0, 0, 0, 0, 0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({ctl, bus.sel_data, bus.final_mem, bus.wb_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got ctl=%b fm=%0h idx=%0h want all 0", ctl, bus.final_mem, bus.wb_idx);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (ctl !== 7'b0 || bus.final_mem !== 32'd0 || bus.wb_idx !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_quiet c=%0d got ctl=%b want 0000000", c, ctl);
            end
        end
    endtask

    task automatic test_vec_store();
        logic       acc;
        logic [6:0] exp_ctl;
        drive_op(1, 1, 1, 1, 1, 32'd4);
        n_tests++;
        if (ctl !== 7'b0001000 || bus.sel_data !== 1'b1) begin
            n_fail++;
            $display("FAIL vst_accept got ctl=%b sd=%b want 0001000 sd=1", ctl, bus.sel_data);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                bus.op_src_alu = 1'b0;
                #1;
            end
            acc     = (c <= 4);
            exp_ctl = {acc, acc, 1'b0, (c <= 4), (c <= 5), (c == 5), 1'b0};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL vst_ctl c=%0d got %b want %b", c, ctl, exp_ctl);
            end
            n_tests++;
            if (bus.final_mem !== ((c <= 5) ? 32'd3 : 32'd0) || bus.sel_data !== (c <= 5)) begin
                n_fail++;
                $display("FAIL vst_fm_sd c=%0d got fm=%0d sd=%b", c, bus.final_mem, bus.sel_data);
            end
            if (acc) begin
                n_tests++;
                if (pcmem !== 32'(c - 1)) begin
                    n_fail++;
                    $display("FAIL vst_addr c=%0d got %0d want %0d", c, pcmem, c - 1);
                end
            end
            if (c == 5) bus.op_valid = 1'b0;
        end
        n_tests++;
        if (pcmem !== 32'd0) begin
            n_fail++;
            $display("FAIL vst_pcmem_wrap got %0d want 0", pcmem);
        end
    endtask

    task automatic test_vec_load();
        logic       acc;
        logic       wbv;
        logic [6:0] exp_ctl;
        drive_op(1, 1, 0, 1, 0, 32'd3);
        n_tests++;
        if (ctl !== 7'b0001000) begin
            n_fail++;
            $display("FAIL vld_accept got %b want 0001000", ctl);
        end
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) bus.op_valid = 1'b0;
            acc     = (c <= 3);
            wbv     = (c >= 3) && (c <= 5);
            exp_ctl = {1'b0, acc, 1'b0, (c <= 5), (c <= 6), (c == 6), wbv};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL vld_ctl c=%0d got %b want %b", c, ctl, exp_ctl);
            end
            n_tests++;
            if (bus.wb_idx !== (wbv ? 32'(c - 3) : 32'd0)) begin
                n_fail++;
                $display("FAIL vld_idx c=%0d got %0d want %0d", c, bus.wb_idx, wbv ? c - 3 : 0);
            end
            n_tests++;
            if (bus.final_mem !== ((c <= 6) ? 32'd2 : 32'd0)) begin
                n_fail++;
                $display("FAIL vld_fm c=%0d got %0d", c, bus.final_mem);
            end
        end
    endtask

    task automatic test_scalar_then_vector();
        logic [6:0] exp_ctl;
        logic       acc;
        drive_op(1, 1, 0, 0, 1, 32'd5);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) bus.op_valid = 1'b0;
            exp_ctl = {1'b0, 1'b0, (c == 1), (c <= 3), 1'b1, (c == 4), (c == 3)};
            n_tests++;
            if (ctl !== exp_ctl || bus.wb_idx !== 32'd0 || bus.final_mem !== 32'd0) begin
                n_fail++;
                $display("FAIL sld_ctl c=%0d got %b idx=%0d fm=%0d want %b idx=0 fm=0",
                         c, ctl, bus.wb_idx, bus.final_mem, exp_ctl);
            end
        end
        tick();
        drive_op(1, 1, 1, 1, 0, 32'd2);
        n_tests++;
        if (ctl !== 7'b0001000 || pcmem !== 32'd0) begin
            n_fail++;
            $display("FAIL s2v_accept got ctl=%b pc=%0d want 0001000 pc=0", ctl, pcmem);
        end
        for (int d = 1; d <= 3; d++) begin
            tick();
            if (d == 1) bus.op_valid = 1'b0;
            acc     = (d <= 2);
            exp_ctl = {acc, acc, 1'b0, acc, 1'b1, (d == 3), 1'b0};
            n_tests++;
            if (ctl !== exp_ctl || bus.final_mem !== 32'd1) begin
                n_fail++;
                $display("FAIL s2v_ctl d=%0d got %b fm=%0d want %b fm=1", d, ctl, bus.final_mem, exp_ctl);
            end
            if (acc) begin
                n_tests++;
                if (pcmem !== 32'(d - 1)) begin
                    n_fail++;
                    $display("FAIL s2v_addr d=%0d got %0d want %0d", d, pcmem, d - 1);
                end
            end
        end
        tick();
        n_tests++;
        if (bus.busy !== 1'b0 || pcmem !== 32'd0) begin
            n_fail++;
            $display("FAIL s2v_end got busy=%b pc=%0d want 0 0", bus.busy, pcmem);
        end
    endtask

    task automatic test_zero_len();
        drive_op(1, 1, 1, 1, 0, 32'd0);
        n_tests++;
        if (ctl !== 7'b0001000) begin
            n_fail++;
            $display("FAIL zl_accept got %b want 0001000", ctl);
        end
        tick();
        bus.op_valid = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000110 || bus.final_mem !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL zl_done got %b fm=%0h want 0000110 fm=ffffffff", ctl, bus.final_mem);
        end
        tick();
        n_tests++;
        if (ctl !== 7'b0 || bus.final_mem !== 32'd0) begin
            n_fail++;
            $display("FAIL zl_idle got %b fm=%0h want 0", ctl, bus.final_mem);
        end
    endtask

    task automatic test_non_mem();
        logic s;
        for (int i = 0; i < 6; i++) begin
            s = ((i % 2) == 1);
            drive_op(1, 0, 1, 1, s, 32'd9);
            n_tests++;
            if (bus.stall !== 1'b0 || bus.sel_data !== s || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL nonmem i=%0d got stall=%b sd=%b busy=%b want 0 %b 0",
                         i, bus.stall, bus.sel_data, bus.busy, s);
            end
            tick();
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL nonmem_state i=%0d got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
            end
        end
        drive_op(0, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        drive_op(1, 1, 1, 0, 1, 32'd7);
        tick();
        n_tests++;
        if (ctl !== 7'b1011100) begin
            n_fail++;
            $display("FAIL b2b_sst c=1 got %b want 1011100", ctl);
        end
        tick();
        n_tests++;
        if (ctl !== 7'b0000110) begin
            n_fail++;
            $display("FAIL b2b_sst_done c=2 got %b want 0000110", ctl);
        end
        drive_op(1, 1, 1, 1, 0, 32'd0);
        tick();
        n_tests++;
        if (ctl !== 7'b0001000) begin
            n_fail++;
            $display("FAIL b2b_accept2 c=3 got %b want 0001000", ctl);
        end
        tick();
        bus.op_valid = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000110) begin
            n_fail++;
            $display("FAIL b2b_done2 c=4 got %b want 0000110", ctl);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        drive_op(1, 1, 0, 1, 0, 32'd8);
        tick();
        bus.op_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.wb_valid !== 1'b1 || bus.wb_idx !== 32'd0 || bus.final_mem !== 32'd7) begin
            n_fail++;
            $display("FAIL rst_pre c=3 got wbv=%b idx=%0d fm=%0d want 1 0 7",
                     bus.wb_valid, bus.wb_idx, bus.final_mem);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (ctl !== 7'b0 || bus.final_mem !== 32'd0 || bus.wb_idx !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid c=4 got ctl=%b fm=%0d idx=%0d want 0", ctl, bus.final_mem, bus.wb_idx);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (ctl !== 7'b0 || bus.wb_idx !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_after c=5 got ctl=%b idx=%0d want 0", ctl, bus.wb_idx);
        end
    endtask

    initial begin
        test_reset();
        test_vec_store();
        test_vec_load();
        test_scalar_then_vector();
        test_zero_len();
        test_non_mem();
        test_back_to_back();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
